// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: two-source round-robin arbiter that owns the select line of
// a 2:1 output mux. One source is granted at a time. Its valid/data are steered
// combinationally to the output, and downstream ready is returned only to it.
// Fairness comes from a per-grant beat limit (MAX_HOLD) that takes effect
// whenever the other source is waiting.
module rr_mux_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_a_valid,
  input  logic [WIDTH-1:0] i_a_data,
  output logic             o_a_ready,
  input  logic             i_b_valid,
  input  logic [WIDTH-1:0] i_b_data,
  output logic             o_b_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic             o_sel,
  output logic             o_busy
);

  // Beat counter must hold 0..MAX_HOLD-1. The extra headroom keeps the
  // width sane for MAX_HOLD = 1.
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  // Count value at which the next transfer exhausts the grant.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_GRANT_A = 2'b01;
  localparam logic [1:0] ST_GRANT_B = 2'b10;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             last_a_r;      // 1: A was served last, 0: B was served last
  logic             last_a_nxt_s;
  logic             sel_r;
  logic             busy_r;

  // Next-state, beat-count and round-robin history decisions.
  always_comb begin
    state_nxt_s  = state_r;
    count_nxt_s  = count_r;
    last_a_nxt_s = last_a_r;
    case (state_r)
      ST_IDLE: begin
        count_nxt_s = {CNT_W{1'b0}};
        if (i_a_valid && i_b_valid) begin
          // Contention: the source that was not served last wins.
          if (last_a_r) begin
            state_nxt_s  = ST_GRANT_B;
            last_a_nxt_s = 1'b0;
          end else begin
            state_nxt_s  = ST_GRANT_A;
            last_a_nxt_s = 1'b1;
          end
        end else if (i_a_valid) begin
          state_nxt_s  = ST_GRANT_A;
          last_a_nxt_s = 1'b1;
        end else if (i_b_valid) begin
          state_nxt_s  = ST_GRANT_B;
          last_a_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT_A: begin
        if (!i_a_valid) begin
          // Granted source went quiet: hand over or go idle. Nothing can be
          // in flight, so switching cannot break a stalled beat.
          count_nxt_s = {CNT_W{1'b0}};
          if (i_b_valid) begin
            state_nxt_s  = ST_GRANT_B;
            last_a_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (i_ready) begin
          // A beat transfers this cycle.
          if (count_r == HOLD_LAST) begin
            count_nxt_s = {CNT_W{1'b0}};
            if (i_b_valid) begin
              state_nxt_s  = ST_GRANT_B;
              last_a_nxt_s = 1'b0;
            end else begin
              state_nxt_s = ST_GRANT_A;
            end
          end else begin
            count_nxt_s = count_r + CNT_W'(1);
          end
        end else begin
          // Stalled with valid held: keep grant and count untouched.
          state_nxt_s = ST_GRANT_A;
          count_nxt_s = count_r;
        end
      end
      ST_GRANT_B: begin
        if (!i_b_valid) begin
          count_nxt_s = {CNT_W{1'b0}};
          if (i_a_valid) begin
            state_nxt_s  = ST_GRANT_A;
            last_a_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (i_ready) begin
          if (count_r == HOLD_LAST) begin
            count_nxt_s = {CNT_W{1'b0}};
            if (i_a_valid) begin
              state_nxt_s  = ST_GRANT_A;
              last_a_nxt_s = 1'b1;
            end else begin
              state_nxt_s = ST_GRANT_B;
            end
          end else begin
            count_nxt_s = count_r + CNT_W'(1);
          end
        end else begin
          state_nxt_s = ST_GRANT_B;
          count_nxt_s = count_r;
        end
      end
      default: begin
        // Unreachable encoding: recover to idle.
        state_nxt_s = ST_IDLE;
        count_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Arbitration state, beat count and round-robin history.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r  <= ST_IDLE;
      count_r  <= {CNT_W{1'b0}};
      last_a_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      count_r  <= count_nxt_s;
      last_a_r <= last_a_nxt_s;
    end
  end

  // Registered mux select and busy flag, decoded from the next grant state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sel_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      sel_r  <= (state_nxt_s == ST_GRANT_A);
      busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

  assign o_sel  = sel_r;
  assign o_busy = busy_r;

  // Zero-latency data steering and ready return for the granted source.
  always_comb begin
    o_valid   = 1'b0;
    o_data    = {WIDTH{1'b0}};
    o_a_ready = 1'b0;
    o_b_ready = 1'b0;
    case (state_r)
      ST_GRANT_A: begin
        o_valid   = i_a_valid;
        o_data    = i_a_data;
        o_a_ready = i_ready;
      end
      ST_GRANT_B: begin
        o_valid   = i_b_valid;
        o_data    = i_b_data;
        o_b_ready = i_ready;
      end
      ST_IDLE: begin
        o_valid   = 1'b0;
        o_data    = {WIDTH{1'b0}};
      end
      default: begin
        o_valid   = 1'b0;
        o_data    = {WIDTH{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter. One instance uses MAX_HOLD = 4 and a
// second uses MAX_HOLD = 1. Both instances share all inputs.
module tb_rr_mux_arbiter;

  logic       i_clk;
  logic       i_rst;
  logic       i_a_valid;
  logic [7:0] i_a_data;
  logic       i_b_valid;
  logic [7:0] i_b_data;
  logic       i_ready;

  logic       o_a_ready, o_b_ready, o_valid, o_sel, o_busy;
  logic [7:0] o_data;
  logic       o_a_ready1, o_b_ready1, o_valid1, o_sel1, o_busy1;
  logic [7:0] o_data1;

  int checks   = 0;
  int failures = 0;
  int a_idx;
  int b_idx;
  logic exp_a;

  rr_mux_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_valid(i_a_valid), .i_a_data(i_a_data), .o_a_ready(o_a_ready),
    .i_b_valid(i_b_valid), .i_b_data(i_b_data), .o_b_ready(o_b_ready),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .o_sel(o_sel), .o_busy(o_busy)
  );

  rr_mux_arbiter #(.WIDTH(8), .MAX_HOLD(1)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_valid(i_a_valid), .i_a_data(i_a_data), .o_a_ready(o_a_ready1),
    .i_b_valid(i_b_valid), .i_b_data(i_b_data), .o_b_ready(o_b_ready1),
    .o_valid(o_valid1), .o_data(o_data1), .i_ready(i_ready),
    .o_sel(o_sel1), .o_busy(o_busy1)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven there.
  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  initial begin
    i_rst = 1'b1; i_a_valid = 1'b0; i_a_data = 8'h00;
    i_b_valid = 1'b0; i_b_data = 8'h00; i_ready = 1'b0;

    // Reset state
    tick(); #1;
    chk("rst_sel", 32'(o_sel), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_a_ready", 32'(o_a_ready), 32'd0);
    chk("rst_b_ready", 32'(o_b_ready), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    tick(); i_rst = 1'b0;

    // Single source A: one idle cycle, then 0x11, 0x22, 0x33
    tick(); i_a_valid = 1'b1; i_a_data = 8'h11; i_ready = 1'b1; #1;
    chk("single_idle_busy", 32'(o_busy), 32'd0);
    chk("single_idle_valid", 32'(o_valid), 32'd0);
    tick(); #1;
    chk("single_sel", 32'(o_sel), 32'd1);
    chk("single_d0", 32'(o_data), 32'h11);
    chk("single_a_ready", 32'(o_a_ready), 32'd1);
    chk("single_b_ready", 32'(o_b_ready), 32'd0);
    tick(); i_a_data = 8'h22; #1;
    chk("single_d1", 32'(o_data), 32'h22);
    tick(); i_a_data = 8'h33; #1;
    chk("single_d2", 32'(o_data), 32'h33);
    tick(); i_a_valid = 1'b0; i_a_data = 8'h00; #1;
    chk("single_drop_valid", 32'(o_valid), 32'd0);
    tick(); #1;
    chk("single_idle_again_busy", 32'(o_busy), 32'd0);
    chk("single_idle_again_sel", 32'(o_sel), 32'd0);

    // Reset asserted mid-stream with A granted and i_ready = 1
    i_a_valid = 1'b1; i_a_data = 8'h44;
    tick(); #1;
    chk("pre_rst_sel", 32'(o_sel), 32'd1);
    chk("pre_rst_a_ready", 32'(o_a_ready), 32'd1);
    i_rst = 1'b1; #1;
    chk("midrst_sel", 32'(o_sel), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_a_ready", 32'(o_a_ready), 32'd0);
    chk("midrst_b_ready", 32'(o_b_ready), 32'd0);
    chk("midrst_data", 32'(o_data), 32'd0);
    tick(); tick(); i_rst = 1'b0;

    // Contention, MAX_HOLD = 4: A first, then 4 A / 4 B beats with no bubble
    a_idx = 0; b_idx = 0;
    i_a_valid = 1'b1; i_b_valid = 1'b1; i_a_data = 8'hA0; i_b_data = 8'hB0; #1;
    chk("cont_idle_busy", 32'(o_busy), 32'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      i_a_data = 8'hA0 + 8'(a_idx);
      i_b_data = 8'hB0 + 8'(b_idx);
      #1;
      exp_a = ((k / 4) % 2 == 0);
      chk("cont_sel", 32'(o_sel), 32'(exp_a));
      chk("cont_valid", 32'(o_valid), 32'd1);
      chk("cont_data", 32'(o_data), exp_a ? 32'(8'hA0 + 8'(a_idx)) : 32'(8'hB0 + 8'(b_idx)));
      chk("cont_a_ready", 32'(o_a_ready), 32'(exp_a));
      chk("cont_b_ready", 32'(o_b_ready), 32'(!exp_a));
      if (exp_a) a_idx++; else b_idx++;
    end

    // Backpressure while B is granted and A is waiting
    tick(); i_ready = 1'b0; i_b_data = 8'hB4; #1;
    chk("bp_sel", 32'(o_sel), 32'd0);
    chk("bp_data", 32'(o_data), 32'hB4);
    chk("bp_valid", 32'(o_valid), 32'd1);
    chk("bp_b_ready", 32'(o_b_ready), 32'd0);
    chk("bp_a_ready", 32'(o_a_ready), 32'd0);
    for (int j = 0; j < 4; j++) begin
      tick(); #1;
      chk("bp_hold_sel", 32'(o_sel), 32'd0);
      chk("bp_hold_data", 32'(o_data), 32'hB4);
      chk("bp_hold_b_ready", 32'(o_b_ready), 32'd0);
      chk("bp_hold_a_ready", 32'(o_a_ready), 32'd0);
    end
    tick(); i_ready = 1'b1; #1;
    chk("bp_release_b_ready", 32'(o_b_ready), 32'd1);
    chk("bp_release_data", 32'(o_data), 32'hB4);
    tick(); i_b_data = 8'hB5; #1;
    chk("bp_next_sel", 32'(o_sel), 32'd0);
    chk("bp_next_data", 32'(o_data), 32'hB5);

    // B drops valid: A takes over, sends 2 beats, then releases to B
    i_b_valid = 1'b0; i_a_data = 8'hA8; #1;
    chk("rel_b_drop_valid", 32'(o_valid), 32'd0);
    tick(); #1;
    chk("rel_a_sel", 32'(o_sel), 32'd1);
    chk("rel_a_d0", 32'(o_data), 32'hA8);
    tick(); i_a_data = 8'hA9; #1;
    chk("rel_a_d1", 32'(o_data), 32'hA9);
    tick(); i_a_valid = 1'b0; i_b_valid = 1'b1; i_b_data = 8'hB5; #1;
    chk("rel_a_drop_valid", 32'(o_valid), 32'd0);
    chk("rel_a_drop_sel", 32'(o_sel), 32'd1);
    tick(); #1;
    chk("rel_b_sel", 32'(o_sel), 32'd0);
    chk("rel_b_data", 32'(o_data), 32'hB5);
    chk("rel_b_ready", 32'(o_b_ready), 32'd1);
    i_a_valid = 1'b1; i_a_data = 8'hAA;
    for (int j = 1; j < 4; j++) begin
      tick(); i_b_data = 8'hB5 + 8'(j); #1;
      chk("rel_b_burst_sel", 32'(o_sel), 32'd0);
      chk("rel_b_burst_data", 32'(o_data), 32'(8'hB5 + 8'(j)));
    end
    tick(); #1;
    chk("rel_back_to_a_sel", 32'(o_sel), 32'd1);
    chk("rel_back_to_a_data", 32'(o_data), 32'hAA);

    // MAX_HOLD = 1 instance: strict alternation, then A streams alone
    i_rst = 1'b1;
    tick(); i_rst = 1'b0;
    a_idx = 0; b_idx = 0;
    i_a_valid = 1'b1; i_b_valid = 1'b1; i_ready = 1'b1;
    i_a_data = 8'hA0; i_b_data = 8'hB0; #1;
    chk("mh1_idle_busy", 32'(o_busy1), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      i_a_data = 8'hA0 + 8'(a_idx);
      i_b_data = 8'hB0 + 8'(b_idx);
      #1;
      exp_a = (k % 2 == 0);
      chk("mh1_alt_sel", 32'(o_sel1), 32'(exp_a));
      chk("mh1_alt_data", 32'(o_data1), exp_a ? 32'(8'hA0 + 8'(a_idx)) : 32'(8'hB0 + 8'(b_idx)));
      if (exp_a) a_idx++; else b_idx++;
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      i_b_valid = 1'b0;
      i_a_data = 8'hA0 + 8'(a_idx);
      #1;
      chk("mh1_stream_sel", 32'(o_sel1), 32'd1);
      chk("mh1_stream_valid", 32'(o_valid1), 32'd1);
      chk("mh1_stream_data", 32'(o_data1), 32'(8'hA0 + 8'(a_idx)));
      a_idx++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
